// File: rtl/key_led_multi.sv
`timescale 1ns/1ps
// key_led_multi
// Debounces NUM_KEYS active-low push-buttons. Each key produces a
// one-cycle press pulse, and the pulses drive a LED register in one of four
// run-time modes: toggle, one-hot, up/down count, flowing light.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   key_in     raw buttons, 0 = pressed, asynchronous to clk
//   mode       0 toggle, 1 one-hot, 2 count, 3 flow (quasi-static)
//   led        LED register, 1 = on
//   key_pulse  one-cycle press flags after debounce
module key_led_multi #(
    parameter int NUM_KEYS     = 4,
    parameter int LED_W        = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int FLOW_DIV     = 25000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [1:0]          mode,
    output logic [LED_W-1:0]    led,
    output logic [NUM_KEYS-1:0] key_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam int PRE_W = (FLOW_DIV > 1) ? $clog2(FLOW_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(FLOW_DIV - 1);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_stable;
    logic [NUM_KEYS-1:0] r_pulse;
    logic [CNT_W-1:0]    r_cnt [NUM_KEYS];

    logic [LED_W-1:0]    r_led;
    logic                r_run;
    logic                r_dir;      // 0 = left, 1 = right
    logic [PRE_W-1:0]    r_presc;
    logic [1:0]          r_mode_q;

    logic [LED_W-1:0]    w_pmask;    // pulses of keys that map onto a LED bit
    logic [LED_W-1:0]    w_lowest;
    logic [LED_W-1:0]    w_flow_next;
    logic                w_mode_chg;
    logic                w_step;

    // Debounce: a mismatch must persist for DEBOUNCE_CYC edges before the
    // stable level follows; the pulse is registered on that same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_stable <= '1;
            r_pulse  <= '0;
            for (int k = 0; k < NUM_KEYS; k++) r_cnt[k] <= '0;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_pulse[k] <= 1'b0;
                if (r_sync2[k] == r_stable[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_MAX) begin
                    r_stable[k] <= r_sync2[k];
                    r_cnt[k]    <= '0;
                    r_pulse[k]  <= ~r_sync2[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    generate
        if (NUM_KEYS >= LED_W) begin : g_mask_trunc
            assign w_pmask = r_pulse[LED_W-1:0];
        end else begin : g_mask_pad
            assign w_pmask = {{(LED_W-NUM_KEYS){1'b0}}, r_pulse};
        end
    endgenerate

    // Isolates the lowest set bit (two's-complement trick).
    assign w_lowest   = w_pmask & (~w_pmask + LED_W'(1));
    assign w_mode_chg = (mode != r_mode_q);
    assign w_step     = r_run && (r_presc == PRE_MAX) && !w_mode_chg;

    always_comb begin
        w_flow_next = '0;
        if (r_led == '0)
            w_flow_next = r_dir ? {1'b1, {(LED_W-1){1'b0}}} : LED_W'(1);
        else if (r_dir)
            w_flow_next = {r_led[0], r_led[LED_W-1:1]};
        else
            w_flow_next = {r_led[LED_W-2:0], r_led[LED_W-1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led    <= '0;
            r_run    <= 1'b0;
            r_dir    <= 1'b0;
            r_presc  <= '0;
            r_mode_q <= 2'd0;
        end else begin
            r_mode_q <= mode;

            if (w_mode_chg)
                r_presc <= '0;
            else if (mode == 2'd3 && r_run)
                r_presc <= (r_presc == PRE_MAX) ? '0 : r_presc + PRE_W'(1);

            case (mode)
                2'd0: r_led <= r_led ^ w_pmask;
                2'd1: if (|w_pmask) r_led <= w_lowest;
                2'd2: begin
                    if (r_pulse[2])
                        r_led <= '0;
                    else if (r_pulse[0] && !r_pulse[1])
                        r_led <= r_led + LED_W'(1);
                    else if (r_pulse[1] && !r_pulse[0])
                        r_led <= r_led - LED_W'(1);
                end
                default: begin
                    // A key event on the wrap edge takes precedence over the step.
                    if (r_pulse[1])
                        r_dir <= ~r_dir;
                    if (r_pulse[2]) begin
                        r_led <= '0;
                        r_run <= 1'b0;
                    end else if (r_pulse[0]) begin
                        r_run <= ~r_run;
                    end else if (!r_pulse[1] && w_step) begin
                        r_led <= w_flow_next;
                    end
                end
            endcase
        end
    end

    assign led       = r_led;
    assign key_pulse = r_pulse;

endmodule

// File: doc/key_led_multi.md
Name: key_led_multi

Overview:
- Parametrised successor to the single-key LED controller.
- Handles NUM_KEYS active-low push-buttons. Each key gets a 2-flop synchroniser and a per-key debounce counter, and produces a one-cycle press pulse.
- Press pulses drive a LED_W-bit LED register in one of four run-time modes: toggle, one-hot, up/down count, flowing light.
- Sits between the board push-buttons and the LED pins.

Parameters:
- NUM_KEYS, 4: number of keys; minimum 3.
- LED_W, 4: LED vector width; minimum 2.
- DEBOUNCE_CYC, 1000000: stable cycles required before a key level is accepted (20 ms at 50 MHz); minimum 2; benches use 4.
- FLOW_DIV, 25000000: clock cycles per flowing-light step; minimum 1; benches use 4.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst_n, input, 1: reset; synchronous, active-low.
- key_in, input, NUM_KEYS: raw buttons; 0 = pressed; asynchronous to clk.
- mode, input, 2: LED mode select; 0 toggle, 1 one-hot, 2 count, 3 flow; quasi-static.
- led, output, LED_W: LED register; 1 = on.
- key_pulse, output, NUM_KEYS: one-cycle press flags after debounce.

Behaviour:
- Reset (rst_n sampled 0 at an edge):
  - sync flops = 1, stable = 1, debounce counters = 0.
  - key_pulse = 0, led = 0.
  - flow run = 0, flow dir = left, flow prescaler = 0.
  - Reset mid-debounce discards progress; no pulse is emitted.
- Synchroniser: two flops per key; sync2 is the debounce input.
- Debounce, per key, each edge:
  - sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYC-1: stable <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any mismatch shorter than DEBOUNCE_CYC cycles leaves stable unchanged.
- Press pulse:
  - key_pulse[k] <= 1 on the edge where stable[k] goes 1->0; 0 otherwise.
  - Latency: key_in falls before edge E0 (first sampling edge); pulse is high from E(DEBOUNCE_CYC+1) to E(DEBOUNCE_CYC+2).
  - Release (0->1) updates stable with no pulse.
  - A key held through reset release produces a pulse DEBOUNCE_CYC+1 edges after reset deasserts.
- LED update: occurs on the edge after key_pulse is high (key_pulse registered -> led registered). Uses mode sampled at that edge.
  - Mode 0 TOGGLE: led[k] ^= 1 for every pulsing k < LED_W; simultaneous pulses all toggle; keys >= LED_W ignored.
  - Mode 1 ONEHOT: led <= 1 << k for the lowest-index pulsing k < LED_W; otherwise hold.
  - Mode 2 COUNT:
    - Priority order: key2 pulse -> led <= 0 (overrides key0/key1).
    - Else key0 alone: led+1, modulo 2^LED_W.
    - Else key1 alone: led-1, modulo 2^LED_W.
    - key0 and key1 together: hold.
  - Mode 3 FLOW:
    - key0 pulse toggles run; key1 pulse toggles dir; key2 pulse -> led <= 0 and run <= 0.
    - While run = 1, the prescaler counts 0..FLOW_DIV-1; on wrap, led takes one step:
      - led == 0: load 1 (dir left) or 1 << (LED_W-1) (dir right).
      - Otherwise rotate one position left or right, wrapping end to end.
    - Prescaler holds while run = 0.
- Mode change:
  - led retained; prescaler cleared to 0.
  - run and dir retained.
  - Debounce is unaffected.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYC=4, FLOW_DIV=4, NUM_KEYS=4, LED_W=4):
1. Reset: rst_n=0 for 3 cycles, key_in=4'hF -> led=0, key_pulse=0 on every cycle; hold 20 cycles after release -> unchanged.
2. Mode 0, key0 low for 12 cycles:
   - key_pulse=4'b0001 for exactly one cycle, at edge E5.
   - led=4'b0001 one cycle later.
   - Release, repeat press -> led=4'b0000.
   - Keys 0 and 2 pressed on the same cycle -> led=4'b0101.
3. Glitch: key1 low for 3 cycles, then high -> key_pulse stays 0, led unchanged. Bounce 0/1/0 on release -> no pulse.
4. Mode 2, from led=0:
   - key0 pressed 3 times -> 3.
   - key1 once -> 2.
   - key2 -> 0.
   - key1 -> 4'hF (wrap).
   - key0 and key1 same cycle -> hold 4'hF.
5. Mode 3 from led=0, key0 press (run=1):
   - led goes 0001, 0010, 0100, 1000, 0001, stepping every 4 cycles.
   - key1 press -> direction reverses (next step from 0001 is 1000).
   - key0 press -> led frozen.
6. Key0 held low; rst_n pulsed low at the 2nd debounce cycle:
   - No pulse during or immediately after reset.
   - Exactly one key_pulse[0], 5 edges after rst_n returns high.
   - led=0001 in mode 0.
